// File: rtl/crc32_fcs_check.sv
`default_nettype none
// ============================================================================
// Module   : crc32_fcs_check
// Purpose  : Receive-side frame checker. Runs the reflected CRC32
//            (poly 0xEDB88320, init 0xFFFFFFFF, no final XOR) over every byte
//            of a frame, including the trailing 4-byte FCS, and compares the
//            register against the magic residue 0xDEBB20E3 at end of frame.
//            Emits one verdict per frame with length and error flags.
// Macro    : CRC32_CHK_STATS_EN - when defined, builds saturating good/bad
//            frame counters; otherwise good_cnt/bad_cnt are tied to zero.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            din[7:0]        - frame byte
//            din_valid       - din is valid
//            din_last        - din is the final byte of the frame
//            din_ready       - byte accepted when din_valid & din_ready
//            done            - one-cycle pulse, verdict outputs valid
//            ok              - residue matches and length legal
//            err_crc         - residue mismatch
//            err_len         - length < MIN_LEN or > MAX_LEN
//            frame_len[15:0] - bytes in frame, saturating at 0xFFFF
//            crc_res[31:0]   - CRC register after the last byte
//            good_cnt[15:0]  - good frame count (stats build only)
//            bad_cnt[15:0]   - bad frame count (stats build only)
// Revision : 1.0 - initial release
// ============================================================================
module crc32_fcs_check #(
   parameter int MAX_LEN = 1518,
   parameter int MIN_LEN = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  din,
   input  logic        din_valid,
   input  logic        din_last,
   output logic        din_ready,
   output logic        done,
   output logic        ok,
   output logic        err_crc,
   output logic        err_len,
   output logic [15:0] frame_len,
   output logic [31:0] crc_res,
   output logic [15:0] good_cnt,
   output logic [15:0] bad_cnt
);

   localparam logic [31:0] C_CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] C_CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] C_CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [15:0] C_MAX_LEN     = 16'(MAX_LEN);
   localparam logic [15:0] C_MIN_LEN     = 16'(MIN_LEN);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_DROP   = 2'd2;
   localparam logic [1:0] S_REPORT = 2'd3;

   // One byte of the reflected CRC, LSB first; equivalent to the table form
   // crc = (crc >> 8) ^ T[crc[7:0] ^ data].
   function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                            input logic [7:0]  data);
      logic [31:0] c;
      c = crc ^ {24'd0, data};
      for (int k = 0; k < 8; k++) begin
         c = c[0] ? ((c >> 1) ^ C_CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

   logic [1:0]  state_q, state_d;
   logic [31:0] crc_q, crc_d;
   logic [15:0] len_q, len_d;
   logic        oversize_q, oversize_d;

   logic        ok_q, err_crc_q, err_len_q;
   logic [15:0] frame_len_q;
   logic [31:0] crc_res_q;

   logic        w_accept;
   logic        w_enter_report;
   logic [15:0] w_len_inc;
   logic [31:0] w_crc_next;
   logic        w_err_len;
   logic        w_err_crc;

   assign din_ready = ~rst & (state_q != S_REPORT);
   assign w_accept  = din_valid & din_ready;

   assign w_len_inc  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
   // The first byte of a frame always starts from the init value, so a
   // frame can begin in IDLE without waiting for a register load.
   assign w_crc_next = crc_step((state_q == S_IDLE) ? C_CRC_INIT : crc_q, din);

   always_comb begin
      state_d    = state_q;
      crc_d      = crc_q;
      len_d      = len_q;
      oversize_d = oversize_q;
      case (state_q)
         S_IDLE: begin
            crc_d      = C_CRC_INIT;
            len_d      = 16'd0;
            oversize_d = 1'b0;
            if (w_accept) begin
               crc_d   = w_crc_next;
               len_d   = 16'd1;
               state_d = din_last ? S_REPORT : S_RUN;
            end
         end
         S_RUN: begin
            if (w_accept) begin
               crc_d = w_crc_next;
               len_d = w_len_inc;
               // A last byte that also overruns still ends the frame here,
               // but carries the oversize flag into the verdict.
               if (w_len_inc > C_MAX_LEN) begin
                  oversize_d = 1'b1;
               end
               if (din_last) begin
                  state_d = S_REPORT;
               end else if (w_len_inc > C_MAX_LEN) begin
                  state_d = S_DROP;
               end
            end
         end
         S_DROP: begin
            // CRC frozen; only the length keeps counting.
            if (w_accept) begin
               len_d = w_len_inc;
               if (din_last) begin
                  state_d = S_REPORT;
               end
            end
         end
         S_REPORT: begin
            state_d    = S_IDLE;
            crc_d      = C_CRC_INIT;
            len_d      = 16'd0;
            oversize_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Verdicts are captured on the edge that accepts the last byte so they
   // are already valid during the REPORT cycle.
   assign w_enter_report = w_accept & din_last;
   assign w_err_len      = (len_d < C_MIN_LEN) | oversize_d;
   assign w_err_crc      = (crc_d != C_CRC_RESIDUE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         crc_q       <= C_CRC_INIT;
         len_q       <= 16'd0;
         oversize_q  <= 1'b0;
         ok_q        <= 1'b0;
         err_crc_q   <= 1'b0;
         err_len_q   <= 1'b0;
         frame_len_q <= 16'd0;
         crc_res_q   <= C_CRC_INIT;
      end else begin
         state_q    <= state_d;
         crc_q      <= crc_d;
         len_q      <= len_d;
         oversize_q <= oversize_d;
         if (w_enter_report) begin
            ok_q        <= ~w_err_len & ~w_err_crc;
            err_crc_q   <= w_err_crc;
            err_len_q   <= w_err_len;
            frame_len_q <= len_d;
            crc_res_q   <= crc_d;
         end
      end
   end

   // Gating with rst suppresses the pulse when reset lands in REPORT.
   assign done      = (state_q == S_REPORT) & ~rst;
   assign ok        = ok_q;
   assign err_crc   = err_crc_q;
   assign err_len   = err_len_q;
   assign frame_len = frame_len_q;
   assign crc_res   = crc_res_q;

`ifdef CRC32_CHK_STATS_EN
   logic [15:0] good_cnt_q;
   logic [15:0] bad_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         good_cnt_q <= 16'd0;
         bad_cnt_q  <= 16'd0;
      end else if (state_q == S_REPORT) begin
         if (ok_q) begin
            if (good_cnt_q != 16'hFFFF) begin
               good_cnt_q <= good_cnt_q + 16'd1;
            end
         end else begin
            if (bad_cnt_q != 16'hFFFF) begin
               bad_cnt_q <= bad_cnt_q + 16'd1;
            end
         end
      end
   end

   assign good_cnt = good_cnt_q;
   assign bad_cnt  = bad_cnt_q;
`else
   assign good_cnt = 16'd0;
   assign bad_cnt  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc32_fcs_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc32_fcs_check
// Purpose  : Self-checking bench for crc32_fcs_check. A table-driven CRC32
//            model computes expected verdicts for directed and random frames.
//            Follows CRC32_CHK_STATS_EN for the expected counter values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc32_fcs_check;

   localparam int          MAXL    = 16;
   localparam int          MINL    = 5;
   localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  din;
   logic        din_valid;
   logic        din_last;
   logic        din_ready;
   logic        done;
   logic        ok;
   logic        err_crc;
   logic        err_len;
   logic [15:0] frame_len;
   logic [31:0] crc_res;
   logic [15:0] good_cnt;
   logic [15:0] bad_cnt;

   crc32_fcs_check #(.MAX_LEN(MAXL), .MIN_LEN(MINL)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_last  (din_last),
      .din_ready (din_ready),
      .done      (done),
      .ok        (ok),
      .err_crc   (err_crc),
      .err_len   (err_len),
      .frame_len (frame_len),
      .crc_res   (crc_res),
      .good_cnt  (good_cnt),
      .bad_cnt   (bad_cnt)
   );

   always #5 clk = ~clk;

   int          vec = 0;
   int          mis = 0;
   logic [31:0] tbl [256];
   logic [7:0]  frm [$];
   int          exp_good = 0;
   int          exp_bad  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         mis++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] crc_of(input logic [7:0] q[$]);
      logic [31:0] r;
      r = 32'hFFFF_FFFF;
      foreach (q[i]) r = (r >> 8) ^ tbl[r[7:0] ^ q[i]];
      return r;
   endfunction

   // Payload of n-4 random bytes followed by its little-endian FCS.
   task automatic build_good(input int n);
      logic [31:0] fcs;
      frm.delete();
      for (int i = 0; i < n - 4; i++) frm.push_back(8'($urandom));
      fcs = ~crc_of(frm);
      for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
   endtask

   task automatic build_rand(input int n);
      frm.delete();
      for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
   endtask

   // Drive every byte of frm; returns just after the edge accepting the last.
   task automatic push_bytes(input bit gaps);
      for (int i = 0; i < frm.size(); i++) begin
         if (gaps) begin
            din_valid = 1'b0;
            din       = 8'($urandom);
            din_last  = 1'($urandom);
            @(posedge clk); #1;
         end
         din_valid = 1'b1;
         din       = frm[i];
         din_last  = (i == frm.size() - 1);
         @(negedge clk);
         chk("ready_in_frame", din_ready, 1);
         chk("no_done_in_frame", done, 0);
         @(posedge clk); #1;
      end
      din_valid = 1'b0;
      din_last  = 1'b0;
   endtask

   task automatic check_report();
      int          n;
      bit          over;
      bit          elen;
      bit          ecrc;
      bit          eok;
      logic [31:0] c;
      n    = frm.size();
      over = (n > MAXL);
      elen = (n < MINL) || over;
      c    = crc_of(frm);
      ecrc = (c != RESIDUE);
      eok  = !elen && !ecrc;
      @(negedge clk);
      chk("done", done, 1);
      chk("ready_report", din_ready, 0);
      chk("err_len", err_len, 32'(elen));
      chk("ok", ok, 32'(eok));
      chk("frame_len", frame_len, 32'(n));
      if (!over) begin
         chk("err_crc", err_crc, 32'(ecrc));
         chk("crc_res", crc_res, c);
      end
      if (eok) exp_good++;
      else     exp_bad++;
      @(posedge clk); #1;
      chk("done_pulse_end", done, 0);
`ifdef CRC32_CHK_STATS_EN
      chk("good_cnt", good_cnt, 32'(exp_good));
      chk("bad_cnt", bad_cnt, 32'(exp_bad));
`else
      chk("good_cnt", good_cnt, 0);
      chk("bad_cnt", bad_cnt, 0);
`endif
   endtask

   task automatic send_frame(input bit gaps);
      push_bytes(gaps);
      check_report();
   endtask

   task automatic load_ref_frame();
      frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
              8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         logic [31:0] c;
         c = 32'(i);
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         tbl[i] = c;
      end

      // Reset state
      rst = 1'b1; din = 8'h00; din_valid = 1'b0; din_last = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_done", done, 0);
      chk("rst_ok", ok, 0);
      chk("rst_err_crc", err_crc, 0);
      chk("rst_err_len", err_len, 0);
      chk("rst_frame_len", frame_len, 0);
      chk("rst_crc_res", crc_res, 32'hFFFF_FFFF);
      chk("rst_good_cnt", good_cnt, 0);
      chk("rst_bad_cnt", bad_cnt, 0);
      chk("rst_ready", din_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", din_ready, 1);
      @(posedge clk); #1;

      // Reference good frame "123456789" + FCS
      load_ref_frame();
      send_frame(1'b0);
      chk("good_crc_const", crc_res, RESIDUE);

      // Held outputs across idle cycles
      repeat (3) @(posedge clk);
      #1;
      chk("held_frame_len", frame_len, 13);
      chk("held_ok", ok, 1);

      // Corrupted byte: first 0x39 becomes 0x38
      load_ref_frame();
      frm[8] = 8'h38;
      send_frame(1'b0);

      // Runt
      frm = '{8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(1'b0);

      // Single-byte frame
      frm = '{8'hA5};
      send_frame(1'b0);

      // Oversize through DROP
      build_rand(20);
      send_frame(1'b0);

      // Last byte exactly one past MAX_LEN
      build_good(MAXL + 1);
      send_frame(1'b0);

      // Exactly MAX_LEN and exactly MIN_LEN good frames
      build_good(MAXL);
      send_frame(1'b0);
      build_good(MINL);
      send_frame(1'b0);

      // Gapped good frame, then immediately another good frame
      load_ref_frame();
      send_frame(1'b1);
      load_ref_frame();
      send_frame(1'b0);

      // Reset mid-frame after 6 bytes, then full resend
      load_ref_frame();
      for (int i = 0; i < 6; i++) begin
         din_valid = 1'b1; din = frm[i]; din_last = 1'b0;
         @(posedge clk); #1;
      end
      din_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_no_done", done, 0);
      chk("midrst_ready", din_ready, 0);
      @(posedge clk); #1;
      exp_good = 0; exp_bad = 0;
      chk("midrst_frame_len", frame_len, 0);
      chk("midrst_crc_res", crc_res, 32'hFFFF_FFFF);
      chk("midrst_good_cnt", good_cnt, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready_after", din_ready, 1);
      @(posedge clk); #1;
      send_frame(1'b0);

      // Reset asserted during REPORT suppresses done
      load_ref_frame();
      push_bytes(1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("rptrst_no_done", done, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_good = 0; exp_bad = 0;
      chk("rptrst_frame_len", frame_len, 0);
      chk("rptrst_good_cnt", good_cnt, 0);
      @(posedge clk); #1;

      // Random frames: good, bit-flipped, and raw random, various lengths
      for (int f = 0; f < 40; f++) begin
         int n;
         int kind;
         n    = $urandom_range(1, 22);
         kind = $urandom_range(0, 3);
         if (n >= 5 && kind < 2) begin
            build_good(n);
            if (kind == 1) begin
               int idx;
               idx = $urandom_range(0, n - 1);
               frm[idx] = frm[idx] ^ (8'h01 << $urandom_range(0, 7));
            end
         end else begin
            build_rand(n);
         end
         send_frame(1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule
`default_nettype wire
